// File: rtl/interp_com_pkg.sv
// Shared definitions for the interpreter byte link: strobe FSM states, status word layout
// and the value returned by a data read from an empty FIFO.
package interp_com_pkg;

  typedef enum logic {
    StWaitLow  = 1'b0,
    StWaitHigh = 1'b1
  } strobe_st_e;

  localparam int unsigned STAT_NEMPTY  = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam logic [31:0] EMPTY_READ_VALUE = 32'hFFFF_FFFF;

  // Assemble the status word returned by a status read.
  function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf,
                                              input logic full, input logic nempty);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: 8] = cnt;
    w[STAT_OVF]          = ovf;
    w[STAT_FULL]         = full;
    w[STAT_NEMPTY]       = nempty;
    return w;
  endfunction

endpackage

// File: rtl/interp_rx_fifo.sv
// Depth x 8 byte FIFO. Pointers carry one extra wrap bit so full and empty are distinct.
// A push while full is only taken when a pop happens in the same cycle.
module interp_rx_fifo
  import interp_com_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [7:0]     mem_q [Depth];
  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; a full push+pop overwrites the head slot after it has been read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/interpreter_receiver.sv
// Inbound byte receiver from the external interpreter: synchronises rx_strobe/rx_data,
// pushes a byte on each synced rising strobe edge and serves CPU data/status loads.
// Optional macro INTERP_RX_ACK_EN enables a 4-phase ack with backpressure when full;
// without it rx_ack_o is tied low and bytes arriving at a full FIFO set the overflow flag.
module interpreter_receiver
  import interp_com_pkg::*;
#(
  parameter int unsigned Depth      = 4,
  parameter int unsigned SyncStages = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_strobe_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rd_en_i,
  input  logic        rd_sel_i,
  output logic [31:0] rd_data_o,
  output logic        rx_avail_o,
  output logic        rx_ack_o
);

  logic [SyncStages-1:0] strobe_sync_q;
  logic [7:0]            data_sync_q [SyncStages];
  logic                  strobe_s;
  logic [7:0]            byte_s;

  strobe_st_e            state_q, state_d;
  logic                  push, pop, accept, status_rd, ovf_set;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rd_data_q, rd_data_d;

  logic [7:0]            fifo_head;
  logic [$clog2(Depth):0] fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [7:0]            cnt8;

  // Synchroniser chains; the strobe chain resets high so a strobe held through reset
  // never looks like a fresh low->high edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      strobe_sync_q <= '1;
      for (int i = 0; i < SyncStages; i++) data_sync_q[i] <= '0;
    end else begin
      strobe_sync_q <= {strobe_sync_q[SyncStages-2:0], rx_strobe_i};
      data_sync_q[0] <= rx_data_i;
      for (int i = 1; i < SyncStages; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign strobe_s = strobe_sync_q[SyncStages-1];
  assign byte_s   = data_sync_q[SyncStages-1];

  assign pop       = rd_en_i & ~rd_sel_i & ~fifo_empty;
  assign status_rd = rd_en_i & rd_sel_i;

`ifdef INTERP_RX_ACK_EN
  assign accept = ~fifo_full | pop;
`else
  assign accept = 1'b1;
`endif

  // Strobe FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StWaitLow;
    else         state_q <= state_d;
  end

  // Strobe FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLow:  if (!strobe_s)          state_d = StWaitHigh;
      StWaitHigh: if (strobe_s && accept) state_d = StWaitLow;
      default:                            state_d = StWaitLow;
    endcase
  end

  // Strobe FSM output: push on an accepted synced rising edge.
  always_comb begin
    push = (state_q == StWaitHigh) && strobe_s && accept;
  end

  interp_rx_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (byte_s),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cnt8       = 8'(fifo_count);
  assign ovf_set    = push & fifo_full & ~pop;
  assign rx_avail_o = ~fifo_empty;

  // Sticky overflow and read-result next state; a new overflow beats a clearing read.
  always_comb begin
    ovf_d     = ovf_set | (ovf_q & ~status_rd);
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (rd_sel_i)        rd_data_d = status_word(cnt8, ovf_q, fifo_full, ~fifo_empty);
      else if (fifo_empty) rd_data_d = EMPTY_READ_VALUE;
      else                 rd_data_d = {24'h0, fifo_head};
    end
  end

  // Overflow flag and registered read result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef INTERP_RX_ACK_EN
  logic ack_q, ack_d;

  // Ack rises after a push and drops once the synced strobe is seen low.
  always_comb begin
    ack_d = ack_q;
    if (push)                  ack_d = 1'b1;
    else if (ack_q && !strobe_s) ack_d = 1'b0;
  end

  // Ack register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ack_q <= 1'b0;
    else         ack_q <= ack_d;
  end

  assign rx_ack_o = ack_q;
`else
  assign rx_ack_o = 1'b0;
`endif

endmodule

// File: tb/tb_interpreter_receiver.sv
// Directed bench for interpreter_receiver (Depth=4, SyncStages=2). Read results are
// checked by a scoreboard monitor; flag outputs are checked inline by the driver.
module tb_interpreter_receiver;

  logic        clk;
  logic        reset;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rx_avail;
  logic        rx_ack;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  interpreter_receiver #(
    .Depth      (4),
    .SyncStages (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_strobe_i (rx_strobe),
    .rx_data_i   (rx_data),
    .rd_en_i     (rd_en),
    .rd_sel_i    (rd_sel),
    .rd_data_o   (rd_data),
    .rx_avail_o  (rx_avail),
    .rx_ack_o    (rx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_en cycle produces one registered result.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (rd_en === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_data: got %h expected none queued", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
    end
  end

  task automatic rd(input logic sel, input logic [31:0] exp);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = sel;
    exp_q.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    @(negedge clk);
    rx_strobe = 1'b1;
    repeat (4) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00; rd_en = 1'b0; rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_avail", {31'b0, rx_avail}, 32'h0);
    check("reset_ack", {31'b0, rx_ack}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte A5 with latency check.
    rx_data = 8'hA5;
    @(negedge clk);
    rx_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("latency_2edges_avail", {31'b0, rx_avail}, 32'h0);
    @(posedge clk); #1;
    check("latency_3edges_avail", {31'b0, rx_avail}, 32'h1);
    repeat (3) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
    rd(1'b0, 32'h0000_00A5);
    check("avail_after_pop", {31'b0, rx_avail}, 32'h0);

    // Empty reads.
    rd(1'b0, 32'hFFFF_FFFF);
    rd(1'b1, 32'h0000_0000);

`ifdef INTERP_RX_ACK_EN
    // Backpressure: fifth byte waits for space, then gets pushed and acked.
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    @(negedge clk);
    rx_data = 8'h05;
    @(negedge clk);
    rx_strobe = 1'b1;
    repeat (8) @(negedge clk);
    check("bp_no_ack", {31'b0, rx_ack}, 32'h0);
    rd(1'b1, 32'h0000_0403);
    rd(1'b0, 32'h0000_0001);
    check("bp_ack_rises", {31'b0, rx_ack}, 32'h1);
    rd(1'b1, 32'h0000_0403);
    rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_ack_falls", {31'b0, rx_ack}, 32'h0);
    for (int i = 2; i <= 5; i++) rd(1'b0, 32'(i));
    check("bp_drained", {31'b0, rx_avail}, 32'h0);
`else
    // Overflow: fifth byte dropped, sticky flag cleared by status read.
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("ack_tied_low", {31'b0, rx_ack}, 32'h0);
    rd(1'b1, 32'h0000_0407);
    rd(1'b1, 32'h0000_0403);
    for (int i = 1; i <= 4; i++) rd(1'b0, 32'(i));
    check("ovf_drained", {31'b0, rx_avail}, 32'h0);
    rd(1'b1, 32'h0000_0000);
`endif

    // Full FIFO: pop and push on the same edge keep count at 4 and order intact.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
    @(negedge clk);
    rx_data = 8'h14;
    @(negedge clk);
    rx_strobe = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rd_en = 1'b1; rd_sel = 1'b0;
    exp_q.push_back(32'h0000_0010);
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
    rd(1'b1, 32'h0000_0403);
    for (int i = 1; i <= 4; i++) rd(1'b0, 32'(8'h10 + i));
    check("same_cycle_drained", {31'b0, rx_avail}, 32'h0);

    // Reset mid-stream discards FIFO; strobe held high across reset is not a byte.
    send_byte(8'h99);
    check("pre_reset_avail", {31'b0, rx_avail}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    rx_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("reset2_rd_data", rd_data, 32'h0);
    check("reset2_avail", {31'b0, rx_avail}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("held_strobe_no_byte", {31'b0, rx_avail}, 32'h0);
    rx_strobe = 1'b0;
    repeat (5) @(negedge clk);
    rx_data = 8'h77;
    @(negedge clk);
    rx_strobe = 1'b1;
    repeat (5) @(negedge clk);
    check("new_edge_byte", {31'b0, rx_avail}, 32'h1);
    rd(1'b1, 32'h0000_0101);
    rx_strobe = 1'b0;
    repeat (4) @(negedge clk);
    rd(1'b0, 32'h0000_0077);
    check("final_avail", {31'b0, rx_avail}, 32'h0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
